// File: rtl/multdiv_issue_if.sv
// Bundles the signals between the issue stage, the execute pipeline, the iterative
// multiply/divide core and the writeback port.
//   slave  : the issue block (multdiv_issue)
//   master : the environment (pipeline + core + register file)
// Signals:
//   issue_valid/issue_is_div/op_a/op_b/dest_reg/flush : execute stage -> issue
//   md_ready/md_result/md_exception                   : core -> issue
//   md_ctrl_mult/md_ctrl_div/md_operand_a/md_operand_b : issue -> core
//   stall/busy                                         : issue -> pipeline
//   wb_valid/wb_reg/wb_data                            : issue -> register file
interface multdiv_issue_if;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  dest_reg;
    logic        flush;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    modport slave (
        input  issue_valid, issue_is_div, op_a, op_b, dest_reg, flush,
        input  md_ready, md_result, md_exception,
        output md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
        output stall, busy, wb_valid, wb_reg, wb_data
    );

    modport master (
        output issue_valid, issue_is_div, op_a, op_b, dest_reg, flush,
        output md_ready, md_result, md_exception,
        input  md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
        input  stall, busy, wb_valid, wb_reg, wb_data
    );
endinterface

// File: rtl/multdiv_issue.sv
// Issue/retire stage for the iterative multiply/divide core.
// Latches a MULT/DIV, pulses a one-cycle start into the core, stalls the pipeline until
// the core is ready (or a watchdog expires), then issues a one-cycle writeback. Core
// exceptions and watchdog expiry retire as an rstatus write instead of the result.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : multdiv_issue_if.slave (pipeline, core and writeback signals)
module multdiv_issue #(
    parameter int unsigned TIMEOUT     = 40,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned RSTATUS_REG = 30,
    parameter int unsigned EXC_MULT    = 4,
    parameter int unsigned EXC_DIV     = 5
) (
    input logic            clock,
    input logic            reset_n,
    multdiv_issue_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] wdog_q;
    logic             is_div_q;
    logic [4:0]       dest_q;
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    logic             ctrl_mult_q;
    logic             ctrl_div_q;
    logic             wb_valid_q;
    logic [4:0]       wb_reg_q;
    logic [31:0]      wb_data_q;

    logic             accept;
    logic             timeout;
    logic [31:0]      exc_code;

    // Only meaningful in IDLE and DONE; other states never look at it.
    assign accept   = bus.issue_valid & ~bus.flush;
    assign timeout  = (wdog_q == CNT_W'(TIMEOUT - 1));
    assign exc_code = is_div_q ? 32'(EXC_DIV) : 32'(EXC_MULT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            wdog_q      <= '0;
            is_div_q    <= 1'b0;
            dest_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            // Start pulses and writeback request are single-cycle by default.
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        op_a_q      <= bus.op_a;
                        op_b_q      <= bus.op_b;
                        dest_q      <= bus.dest_reg;
                        is_div_q    <= bus.issue_is_div;
                        ctrl_div_q  <= bus.issue_is_div;
                        ctrl_mult_q <= ~bus.issue_is_div;
                        state_q     <= StStart;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StStart: begin
                    // md_ready may still be high from the previous op; ignore it here.
                    wdog_q  <= '0;
                    state_q <= bus.flush ? StIdle : StBusy;
                end
                StBusy: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                    end else if (bus.md_ready || timeout) begin
                        wb_valid_q <= 1'b1;
                        state_q    <= StDone;
                        if (bus.md_ready && !bus.md_exception) begin
                            wb_reg_q  <= dest_q;
                            wb_data_q <= bus.md_result;
                        end else begin
                            wb_reg_q  <= 5'(RSTATUS_REG);
                            wb_data_q <= exc_code;
                        end
                    end else begin
                        wdog_q <= wdog_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.md_ctrl_mult = ctrl_mult_q;
    assign bus.md_ctrl_div  = ctrl_div_q;
    assign bus.md_operand_a = op_a_q;
    assign bus.md_operand_b = op_b_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_reg       = wb_reg_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.busy         = (state_q != StIdle);
    // The accepting instruction is held in the same cycle it is latched from IDLE.
    assign bus.stall        = (state_q == StStart) || (state_q == StBusy) ||
                              ((state_q == StIdle) && accept);

endmodule

// File: tb/tb_multdiv_issue.sv
module tb_multdiv_issue;

    localparam int TIMEOUT = 40;
    localparam int WIN     = TIMEOUT + 6;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    // Next operation presented in DONE for back-to-back issue.
    logic        nx_div;
    logic [31:0] nx_a;
    logic [31:0] nx_b;
    logic [4:0]  nx_dest;

    multdiv_issue_if bus ();

    multdiv_issue dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ctrl_mult"}, 32'(bus.md_ctrl_mult), 32'd0);
        check({tag, "_ctrl_div"},  32'(bus.md_ctrl_div),  32'd0);
        check({tag, "_opa"},       bus.md_operand_a,      32'd0);
        check({tag, "_opb"},       bus.md_operand_b,      32'd0);
        check({tag, "_wb_valid"},  32'(bus.wb_valid),     32'd0);
        check({tag, "_wb_reg"},    32'(bus.wb_reg),       32'd0);
        check({tag, "_wb_data"},   bus.wb_data,           32'd0);
        check({tag, "_stall"},     32'(bus.stall),        32'd0);
        check({tag, "_busy"},      32'(bus.busy),         32'd0);
    endtask

    // One operation. k=0 is the START cycle, k=j is the j-th BUSY cycle. ready_at<1 means
    // the core never answers. pre_accepted: the op was already latched (we are in START).
    // chain: present the nx_* op during the DONE cycle and return in the following START.
    task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dest, input int ready_at,
                          input logic exc, input logic [31:0] res, input int flush_at,
                          input bit stale, input bit pre_accepted, input bit chain);
        int          done_k;
        bit          answered;
        bit          ex;
        bit          flushed;
        int          n_mult = 0;
        int          n_div = 0;
        int          n_both = 0;
        int          n_stall = 0;
        int          n_opbad = 0;
        int          n_wb = 0;
        int          wb_k = -1;
        logic [4:0]  got_reg = '0;
        logic [31:0] got_data = '0;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;

        // Reference: retire one cycle after the answering BUSY cycle, or after TIMEOUT
        // silent BUSY cycles with a forced exception; a flush before that cancels it.
        answered = (ready_at >= 1) && (ready_at <= TIMEOUT);
        done_k   = answered ? ready_at + 1 : TIMEOUT + 1;
        ex       = answered ? exc : 1'b1;
        flushed  = (flush_at >= 0) && (flush_at < done_k);
        exp_reg  = ex ? 5'd30 : dest;
        exp_data = ex ? (is_div ? 32'd5 : 32'd4) : res;

        if (!pre_accepted) begin
            @(posedge clock); #1;
            bus.issue_valid  = 1'b1;
            bus.issue_is_div = is_div;
            bus.op_a         = a;
            bus.op_b         = b;
            bus.dest_reg     = dest;
            bus.flush        = 1'b0;
            bus.md_ready     = stale;
            @(negedge clock);
            check({tag, "_accept_stall"}, 32'(bus.stall), 32'd1);
            @(posedge clock); #1;
            bus.issue_valid  = 1'b0;
            bus.issue_is_div = 1'($urandom());
            bus.op_a         = $urandom();
            bus.op_b         = $urandom();
            bus.dest_reg     = 5'($urandom());
        end

        for (int k = 0; k < WIN; k++) begin
            bus.md_ready     = (k == ready_at) || (stale && k == 0);
            bus.md_result    = (k == ready_at) ? res : $urandom();
            bus.md_exception = (k == ready_at) ? exc : 1'($urandom());
            bus.flush        = (k == flush_at);
            if (chain && k == done_k) begin
                bus.issue_valid  = 1'b1;
                bus.issue_is_div = nx_div;
                bus.op_a         = nx_a;
                bus.op_b         = nx_b;
                bus.dest_reg     = nx_dest;
            end
            @(negedge clock);
            if (bus.md_ctrl_mult) n_mult++;
            if (bus.md_ctrl_div) n_div++;
            if (bus.md_ctrl_mult && bus.md_ctrl_div) n_both++;
            if (bus.stall) n_stall++;
            if (bus.busy && (bus.md_operand_a !== a || bus.md_operand_b !== b)) n_opbad++;
            if (bus.wb_valid) begin
                n_wb++;
                wb_k     = k;
                got_reg  = bus.wb_reg;
                got_data = bus.wb_data;
            end
            @(posedge clock); #1;
            bus.issue_valid = 1'b0;
            bus.flush       = 1'b0;
            bus.md_ready    = 1'b0;
            if (chain && k == done_k) break;
        end

        check({tag, "_mult_pulses"}, 32'(n_mult), is_div ? 32'd0 : 32'd1);
        check({tag, "_div_pulses"},  32'(n_div),  is_div ? 32'd1 : 32'd0);
        check({tag, "_both_pulses"}, 32'(n_both), 32'd0);
        check({tag, "_stall_cycles"}, 32'(n_stall), flushed ? 32'(flush_at + 1) : 32'(done_k));
        check({tag, "_operands_held"}, 32'(n_opbad), 32'd0);
        check({tag, "_wb_count"}, 32'(n_wb), flushed ? 32'd0 : 32'd1);
        if (!flushed) begin
            check({tag, "_wb_cycle"}, 32'(wb_k), 32'(done_k));
            check({tag, "_wb_reg"},   32'(got_reg), 32'(exp_reg));
            check({tag, "_wb_data"},  got_data, exp_data);
        end
        if (chain) begin
            // Now in the START of the chained op.
            #1;
            check({tag, "_b2b_opa"},  bus.md_operand_a, nx_a);
            check({tag, "_b2b_mult"}, 32'(bus.md_ctrl_mult), nx_div ? 32'd0 : 32'd1);
            check({tag, "_b2b_div"},  32'(bus.md_ctrl_div),  nx_div ? 32'd1 : 32'd0);
            check({tag, "_b2b_stall"}, 32'(bus.stall), 32'd1);
        end else begin
            @(negedge clock);
            check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int n_wb;
        checks           = 0;
        errors           = 0;
        reset_n          = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_is_div = 1'b0;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.dest_reg     = '0;
        bus.flush        = 1'b0;
        bus.md_ready     = 1'b0;
        bus.md_result    = '0;
        bus.md_exception = 1'b0;
        nx_div           = 1'b0;
        nx_a             = '0;
        nx_b             = '0;
        nx_dest          = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero_outs("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // MULT 7x6 -> r5, core answers on the 33rd BUSY cycle.
        run_op("mult_7x6", 1'b0, 32'd7, 32'd6, 5'd5, 33, 1'b0, 32'd42, -1, 0, 0, 0);
        // DIV 100/0 -> r8, core flags an exception.
        run_op("div_by_0", 1'b1, 32'd100, 32'd0, 5'd8, 12, 1'b1, 32'hdead_beef, -1, 0, 0, 0);
        // Stale md_ready during START must not retire the op early.
        run_op("stale_rdy", 1'b0, 32'd3, 32'd9, 5'd11, 5, 1'b0, 32'd27, -1, 1, 0, 0);
        // Core never answers: watchdog forces a MULT exception.
        run_op("timeout", 1'b0, 32'h1234, 32'h5678, 5'd17, -1, 1'b0, 32'd0, -1, 0, 0, 0);
        // Core answers exactly at the watchdog limit: the real answer wins.
        run_op("rdy_at_lim", 1'b1, 32'd50, 32'd7, 5'd2, TIMEOUT, 1'b0, 32'd7, -1, 0, 0, 0);
        // Flush on the 10th BUSY cycle; late md_ready must be ignored.
        run_op("flush_busy", 1'b1, 32'd81, 32'd9, 5'd4, 20, 1'b0, 32'd9, 10, 0, 0, 0);
        // Flush during START.
        run_op("flush_start", 1'b0, 32'd1, 32'd1, 5'd6, 3, 1'b0, 32'd1, 0, 0, 0, 0);
        // r0 destination still produces a writeback request.
        run_op("dest_r0", 1'b0, 32'd2, 32'd2, 5'd0, 1, 1'b0, 32'd4, -1, 0, 0, 0);

        // Back-to-back: DIV retires while a MULT is offered in DONE.
        nx_div  = 1'b0;
        nx_a    = 32'h0000_0011;
        nx_b    = 32'h0000_0022;
        nx_dest = 5'd9;
        run_op("b2b_div", 1'b1, 32'd144, 32'd12, 5'd7, 4, 1'b0, 32'd12, -1, 0, 0, 1);
        run_op("b2b_mult", 1'b0, nx_a, nx_b, nx_dest, 6, 1'b0, 32'h242, -1, 0, 1, 0);

        // Randomized operations.
        for (int i = 0; i < 8; i++) begin
            logic        r_div;
            logic [31:0] r_a;
            logic [31:0] r_b;
            logic [4:0]  r_dest;
            int          r_rdy;
            logic        r_exc;
            logic [31:0] r_res;
            int          r_flush;
            bit          r_stale;
            r_div   = 1'($urandom());
            r_a     = $urandom();
            r_b     = $urandom();
            r_dest  = 5'($urandom());
            r_rdy   = int'($urandom_range(1, 45));
            r_exc   = ($urandom_range(0, 3) == 0);
            r_res   = $urandom();
            r_flush = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            r_stale = 1'($urandom());
            run_op($sformatf("rand%0d", i), r_div, r_a, r_b, r_dest, r_rdy, r_exc, r_res,
                   r_flush, r_stale, 0, 0);
        end

        // Issue together with flush in IDLE is not accepted.
        @(posedge clock); #1;
        bus.issue_valid = 1'b1;
        bus.flush       = 1'b1;
        @(negedge clock);
        check("idle_flush_stall", 32'(bus.stall), 32'd0);
        @(posedge clock); #1;
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        @(negedge clock);
        check("idle_flush_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-BUSY clears everything at once and abandons the op.
        @(posedge clock); #1;
        bus.issue_valid  = 1'b1;
        bus.issue_is_div = 1'b0;
        bus.op_a         = 32'hcafe;
        bus.op_b         = 32'hf00d;
        bus.dest_reg     = 5'd12;
        @(posedge clock); #1;
        bus.issue_valid = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_zero_outs("async_rst");
        @(posedge clock); #1;
        reset_n       = 1'b1;
        bus.md_ready  = 1'b1;
        bus.md_result = 32'h55;
        n_wb          = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (bus.wb_valid) n_wb++;
            @(posedge clock); #1;
            bus.md_ready = 1'b0;
        end
        check("post_rst_no_wb", 32'(n_wb), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
- Upstream issue/retire stage for the iterative multiply/divide unit. Sits between the execute stage and the multdiv core.
- Captures a MULT/DIV instruction's operands and destination register. Fires a one-cycle start pulse into the core, stalls the pipeline until the core reports ready, then presents a single-cycle writeback request.
- Maps core exceptions onto an rstatus write and adds a watchdog so that a hung core can never freeze the pipeline.

Parameters:
- TIMEOUT, 40, number of BUSY cycles without md_ready before a forced exception retire. Must be ≥ 34, i.e. longer than the core's 32-iteration worst case plus setup.
- CNT_W, 6, width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT.
- RSTATUS_REG, 30, register index written on an exception.
- EXC_MULT, 4, rstatus value written for a multiply exception.
- EXC_DIV, 5, rstatus value written for a divide exception.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  the execute stage holds a MULT or DIV this cycle.
- issue_is_div  in  1  1 = DIV, 0 = MULT; qualified by issue_valid.
- op_a  in  32  multiplicand / dividend.
- op_b  in  32  multiplier / divisor.
- dest_reg  in  5  architectural destination register.
- flush  in  1  squash: abort any in-flight or accepted operation.
- md_ready  in  1  core result-ready flag.
- md_result  in  32  core result.
- md_exception  in  1  core exception (overflow or divide by zero); valid with md_ready.
- md_ctrl_mult  out  1  one-cycle start pulse, multiply.
- md_ctrl_div  out  1  one-cycle start pulse, divide.
- md_operand_a  out  32  registered op_a, held stable IDLE→DONE.
- md_operand_b  out  32  registered op_b, held stable IDLE→DONE.
- stall  out  1  freeze fetch/decode/execute.
- busy  out  1  an operation is outstanding (state ≠ IDLE).
- wb_valid  out  1  one-cycle writeback request.
- wb_reg  out  5  writeback register index.
- wb_data  out  32  writeback data.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All registered outputs 0: md_ctrl_*, md_operand_*, wb_*, watchdog counter.
  - stall=0, busy=0.
  - Reset mid-operation abandons the operation; no wb_valid is ever produced for it.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - issue_valid & ~flush: latch op_a, op_b, dest_reg and is_div; next state START.
  - stall is combinational, equal to issue_valid & ~flush, so the issuing instruction is held in the same cycle.
- START (exactly 1 cycle):
  - md_ctrl_div = is_div, md_ctrl_mult = ~is_div; both are registered outputs.
  - md_ready is ignored, because the core may still show ready from the previous operation.
  - Watchdog cleared. Next state BUSY.
  - stall=1.
- BUSY:
  - stall=1; watchdog increments each cycle.
  - On md_ready: capture md_result and md_exception; next state DONE.
  - If the watchdog reaches TIMEOUT-1 without md_ready: next state DONE with exception forced to 1.
- DONE (1 cycle):
  - wb_valid=1; stall=0, so the pipeline advances.
  - No exception: wb_reg = latched dest_reg, wb_data = captured md_result.
  - Exception: wb_reg = RSTATUS_REG, wb_data = EXC_DIV if is_div, else EXC_MULT. The result is discarded.
  - wb_reg=0 with no exception: wb_valid still asserts; the register file ignores r0.
  - If issue_valid & ~flush in this cycle: latch the new operation and go to START (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- flush:
  - In START or BUSY: next state IDLE, no wb_valid, stall drops the following cycle.
  - The core may finish later; its md_ready is ignored in IDLE.
  - flush in DONE does not suppress the current wb_valid; it only blocks a new issue.
- Latency: issue edge → START (md_ctrl pulse) → BUSY ≥ 1 cycle → DONE. Minimum from accept to wb_valid is 3 cycles.
- busy = (state ≠ IDLE); stall = busy & ~DONE, OR'd with the IDLE accept term.
- md_ctrl_mult and md_ctrl_div are never high together and never high for more than 1 cycle.

Test Plan:
- MULT 7×6 into r5, core ready after 33 BUSY cycles with md_result=42 → exactly one md_ctrl_mult pulse; stall high 34 cycles; one wb_valid with wb_reg=5, wb_data=42.
- DIV 100/0 into r8, core returns md_exception=1 → wb_valid with wb_reg=30, wb_data=5; no r8 write.
- md_ready held high from the previous op during START → ignored; the retire waits for a fresh md_ready in BUSY.
- Core never asserts md_ready, MULT issued → forced DONE after 40 BUSY cycles; wb_reg=30, wb_data=4; stall released.
- flush asserted on the 10th BUSY cycle → IDLE next cycle; no wb_valid even when md_ready arrives later.
- Back-to-back: DIV retires while the next MULT is valid in DONE → wb_valid and new operand latch in the same cycle; md_ctrl_mult pulses the next cycle; async reset_n low mid-BUSY → all outputs 0 immediately.
